// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: opcodes, funct3 encodings, stage registers and MEM FSM state.
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [3:0] {
        rf_alu_out  = 4'd0,
        rf_br_en    = 4'd1,
        rf_u_imm    = 4'd2,
        rf_lw       = 4'd3,
        rf_pc_plus4 = 4'd4,
        rf_lb       = 4'd5,
        rf_lbu      = 4'd6,
        rf_lh       = 4'd7,
        rf_lhu      = 4'd8
    } regfilemux_sel_t;

    typedef enum logic [0:0] {
        MEM_IDLE    = 1'b0,
        MEM_PENDING = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic            valid;
        logic [31:0]     pc;
        rv32i_opcode     opcode;
        logic [2:0]      funct3;
        logic [31:0]     alu_out;
        logic            br_en;
        logic [31:0]     u_imm;
        logic [31:0]     rs2_v;
        logic [4:0]      rd_s;
        logic            regf_we;
        regfilemux_sel_t regfilemux_sel;
    } ex_mem_stage_reg_t;

    typedef struct packed {
        logic            valid;
        logic [31:0]     pc;
        rv32i_opcode     opcode;
        logic [2:0]      funct3;
        logic [31:0]     alu_out;
        logic            br_en;
        logic [31:0]     u_imm;
        logic [4:0]      rd_s;
        logic            regf_we;
        regfilemux_sel_t regfilemux_sel;
        logic [31:0]     dmem_addr;
        logic [3:0]      dmem_rmask;
        logic [3:0]      dmem_wmask;
        logic [31:0]     dmem_wdata;
    } mem_wb_stage_reg_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data memory: access width and address offset to byte masks,
// lane-shifted store data and a misalignment flag.
module mem_lane_align
    import rv32i_types::*;
(
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2_v,
    output logic [3:0]  rmask,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic        misaligned
);

    logic [3:0] mask;
    logic       bad_width;

    always_comb begin
        mask       = 4'b0000;
        wdata      = 32'h0;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                mask  = 4'b0001 << addr_lo;
                wdata = {24'h0, rs2_v[7:0]} << {addr_lo, 3'b000};
            end
            2'b01: begin
                mask       = 4'b0011 << {addr_lo[1], 1'b0};
                wdata      = {16'h0, rs2_v[15:0]} << {addr_lo[1], 4'b0000};
                misaligned = addr_lo[0];
            end
            2'b10: begin
                mask       = 4'b1111;
                wdata      = rs2_v;
                misaligned = (addr_lo != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
        // funct3[2] only means "unsigned" for sub-word loads; anything else is an
        // undefined encoding and retires as a no-op like a misaligned access.
        bad_width = funct3[2] && (is_store || funct3[1]);
        if (bad_width) begin
            misaligned = 1'b1;
        end
    end

    assign rmask = (is_load  && !misaligned) ? mask : 4'b0000;
    assign wmask = (is_store && !misaligned) ? mask : 4'b0000;

endmodule

// File: rtl/mem_stage.sv
// RV32I MEM stage: issues single-cycle dmem requests, tracks the one outstanding
// access and freezes the pipeline until its response returns.
//
//   state       | meaning
//   MEM_IDLE    | no access outstanding
//   MEM_PENDING | request issued, waiting for dmem_resp
module mem_stage
    import rv32i_types::*;
#(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  ex_mem_stage_reg_t      ex_mem,
    input  logic                   dmem_resp,
    output logic [31:0]            dmem_addr,
    output logic [3:0]             dmem_rmask,
    output logic [3:0]             dmem_wmask,
    output logic [31:0]            dmem_wdata,
    output mem_wb_stage_reg_t      mem_wb,
    output logic                   freeze_stall,
    output logic [31:0]            mem_fwd_data,
    output logic                   mem_fwd_is_load,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    mem_state_t        state;
    logic              is_load;
    logic              is_store;
    logic              is_mem;
    logic              issue;
    logic [3:0]        al_rmask;
    logic [3:0]        al_wmask;
    logic [31:0]       al_wdata;
    logic              misaligned;
    mem_wb_stage_reg_t wb_next;

    assign is_load  = ex_mem.valid && (ex_mem.opcode == op_load);
    assign is_store = ex_mem.valid && (ex_mem.opcode == op_store);
    assign is_mem   = is_load || is_store;

    mem_lane_align u_align (
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (ex_mem.funct3),
        .addr_lo    (ex_mem.alu_out[1:0]),
        .rs2_v      (ex_mem.rs2_v),
        .rmask      (al_rmask),
        .wmask      (al_wmask),
        .wdata      (al_wdata),
        .misaligned (misaligned)
    );

    // A response in PENDING releases the freeze in the same cycle so a waiting op can issue.
    assign freeze_stall = !rst && (state == MEM_PENDING) && !dmem_resp;
    assign issue        = !rst && is_mem && !freeze_stall && !misaligned;

    assign dmem_addr  = issue ? {ex_mem.alu_out[31:2], 2'b00} : 32'h0;
    assign dmem_rmask = issue ? al_rmask : 4'b0000;
    assign dmem_wmask = issue ? al_wmask : 4'b0000;
    assign dmem_wdata = (issue && is_store) ? al_wdata : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MEM_IDLE;
        end else if (issue) begin
            state <= MEM_PENDING;
        end else if (dmem_resp) begin
            state <= MEM_IDLE;
        end
    end

    always_comb begin
        wb_next                = '0;
        wb_next.valid          = ex_mem.valid;
        wb_next.pc             = ex_mem.pc;
        wb_next.opcode         = ex_mem.opcode;
        wb_next.funct3         = ex_mem.funct3;
        wb_next.alu_out        = ex_mem.alu_out;
        wb_next.br_en          = ex_mem.br_en;
        wb_next.u_imm          = ex_mem.u_imm;
        wb_next.rd_s           = ex_mem.rd_s;
        wb_next.regf_we        = ex_mem.regf_we && !(is_mem && misaligned);
        wb_next.regfilemux_sel = ex_mem.regfilemux_sel;
        wb_next.dmem_addr      = ex_mem.alu_out;
        wb_next.dmem_rmask     = dmem_rmask;
        wb_next.dmem_wmask     = dmem_wmask;
        wb_next.dmem_wdata     = dmem_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wb <= '0;
        end else if (!freeze_stall) begin
            mem_wb <= wb_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (freeze_stall) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    always_comb begin
        mem_fwd_data = 32'h0;
        case (ex_mem.regfilemux_sel)
            rf_br_en:    mem_fwd_data = {31'h0, ex_mem.br_en};
            rf_u_imm:    mem_fwd_data = ex_mem.u_imm;
            rf_alu_out:  mem_fwd_data = ex_mem.alu_out;
            rf_pc_plus4: mem_fwd_data = ex_mem.pc + 32'd4;
            default:     mem_fwd_data = 32'h0;
        endcase
    end

    assign mem_fwd_is_load = is_load;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed request, freeze, pipeline-register and
// counter values, with a 2-bit stall counter so wrap-around is exercised.
module tb_mem_stage;
    import rv32i_types::*;

    logic              clk = 1'b0;
    logic              rst;
    ex_mem_stage_reg_t ex_mem;
    logic              dmem_resp;
    logic [31:0]       dmem_addr;
    logic [3:0]        dmem_rmask;
    logic [3:0]        dmem_wmask;
    logic [31:0]       dmem_wdata;
    mem_wb_stage_reg_t mem_wb;
    logic              freeze_stall;
    logic [31:0]       mem_fwd_data;
    logic              mem_fwd_is_load;
    logic [1:0]        stall_cycles;

    int vectors = 0;
    int errors  = 0;

    mem_stage #(.STALL_CNT_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_mem          (ex_mem),
        .dmem_resp       (dmem_resp),
        .dmem_addr       (dmem_addr),
        .dmem_rmask      (dmem_rmask),
        .dmem_wmask      (dmem_wmask),
        .dmem_wdata      (dmem_wdata),
        .mem_wb          (mem_wb),
        .freeze_stall    (freeze_stall),
        .mem_fwd_data    (mem_fwd_data),
        .mem_fwd_is_load (mem_fwd_is_load),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ex_mem_stage_reg_t mk(input rv32i_opcode op, input logic [2:0] f3,
                                             input logic [31:0] alu, input logic [31:0] rs2,
                                             input logic [4:0] rd, input logic we,
                                             input regfilemux_sel_t sel);
        ex_mem_stage_reg_t r;
        r                = '0;
        r.valid          = 1'b1;
        r.pc             = 32'h0000_1000;
        r.opcode         = op;
        r.funct3         = f3;
        r.alu_out        = alu;
        r.rs2_v          = rs2;
        r.rd_s           = rd;
        r.regf_we        = we;
        r.regfilemux_sel = sel;
        return r;
    endfunction

    initial begin
        rst       = 1'b1;
        dmem_resp = 1'b0;
        ex_mem    = mk(op_store, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, rf_alu_out);
        #1;
        chk("rst_wmask", 32'(dmem_wmask), 32'h0);
        chk("rst_addr", dmem_addr, 32'h0);
        tick();
        tick();
        chk("rst_wb_zero", 32'(mem_wb == '0), 32'd1);
        chk("rst_stall_cnt", 32'(stall_cycles), 32'd0);
        chk("rst_freeze", 32'(freeze_stall), 32'd0);
        rst = 1'b0;

        // 1: SW, response three cycles after issue
        #1;
        chk("t1_wmask", 32'(dmem_wmask), 32'hF);
        chk("t1_rmask", 32'(dmem_rmask), 32'h0);
        chk("t1_addr", dmem_addr, 32'h100);
        chk("t1_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("t1_freeze_issue", 32'(freeze_stall), 32'd0);
        tick();
        ex_mem = '0;
        #1;
        chk("t1_freeze_wait", 32'(freeze_stall), 32'd1);
        chk("t1_wb_wmask", 32'(mem_wb.dmem_wmask), 32'hF);
        chk("t1_no_reissue", 32'(dmem_wmask), 32'h0);
        tick();
        tick();
        dmem_resp = 1'b1;
        #1;
        chk("t1_freeze_resp", 32'(freeze_stall), 32'd0);
        tick();
        dmem_resp = 1'b0;
        chk("t1_stall_cnt", 32'(stall_cycles), 32'd2);

        // 2: SB to byte 3
        ex_mem = mk(op_store, 3'b000, 32'h203, 32'h000000A5, 5'd0, 1'b0, rf_alu_out);
        #1;
        chk("t2_addr", dmem_addr, 32'h200);
        chk("t2_wmask", 32'(dmem_wmask), 32'h8);
        chk("t2_wdata", dmem_wdata, 32'hA5000000);
        tick();
        ex_mem    = '0;
        dmem_resp = 1'b1;
        chk("t2_wb_addr", mem_wb.dmem_addr, 32'h203);
        chk("t2_wb_wdata", mem_wb.dmem_wdata, 32'hA5000000);
        tick();
        dmem_resp = 1'b0;
        chk("t2_stall_cnt", 32'(stall_cycles), 32'd2);

        // 3: LH upper half, with an ADD waiting behind it
        ex_mem = mk(op_load, 3'b001, 32'h302, 32'h0, 5'd7, 1'b1, rf_lh);
        #1;
        chk("t3_rmask", 32'(dmem_rmask), 32'hC);
        chk("t3_addr", dmem_addr, 32'h300);
        chk("t3_fwd_is_load", 32'(mem_fwd_is_load), 32'd1);
        chk("t3_fwd_load_sel", mem_fwd_data, 32'h0);
        tick();
        ex_mem = mk(op_reg, 3'b000, 32'h55, 32'h0, 5'd3, 1'b1, rf_alu_out);
        #1;
        chk("t3_freeze", 32'(freeze_stall), 32'd1);
        chk("t3_fwd_alu", mem_fwd_data, 32'h55);
        tick();
        chk("t3_wb_hold_addr", mem_wb.dmem_addr, 32'h302);
        chk("t3_wb_hold_rd", 32'(mem_wb.rd_s), 32'd7);
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;
        chk("t3_wb_adv_alu", mem_wb.alu_out, 32'h55);
        chk("t3_wb_adv_rd", 32'(mem_wb.rd_s), 32'd3);
        chk("t3_stall_cnt", 32'(stall_cycles), 32'd3);

        // 4: LW then SW, LW response coincides with SW in MEM
        ex_mem = mk(op_load, 3'b010, 32'h400, 32'h0, 5'd9, 1'b1, rf_lw);
        #1;
        chk("t4_lw_rmask", 32'(dmem_rmask), 32'hF);
        tick();
        ex_mem    = mk(op_store, 3'b010, 32'h404, 32'h12345678, 5'd0, 1'b0, rf_alu_out);
        dmem_resp = 1'b1;
        #1;
        chk("t4_freeze", 32'(freeze_stall), 32'd0);
        chk("t4_sw_wmask", 32'(dmem_wmask), 32'hF);
        chk("t4_sw_addr", dmem_addr, 32'h404);
        chk("t4_sw_wdata", dmem_wdata, 32'h12345678);
        tick();
        ex_mem    = '0;
        dmem_resp = 1'b0;
        #1;
        chk("t4_still_pending", 32'(freeze_stall), 32'd1);
        chk("t4_wb_wmask", 32'(mem_wb.dmem_wmask), 32'hF);
        tick();
        chk("t4_stall_wrap", 32'(stall_cycles), 32'd0);
        dmem_resp = 1'b1;
        tick();
        dmem_resp = 1'b0;

        // 5: misaligned LW retires as a no-op
        ex_mem = mk(op_load, 3'b010, 32'h101, 32'h0, 5'd4, 1'b1, rf_lw);
        #1;
        chk("t5_rmask", 32'(dmem_rmask), 32'h0);
        chk("t5_freeze", 32'(freeze_stall), 32'd0);
        tick();
        ex_mem = '0;
        #1;
        chk("t5_no_freeze", 32'(freeze_stall), 32'd0);
        chk("t5_wb_valid", 32'(mem_wb.valid), 32'd1);
        chk("t5_wb_regf_we", 32'(mem_wb.regf_we), 32'd0);
        chk("t5_stall_cnt", 32'(stall_cycles), 32'd0);

        // forwarding selects
        ex_mem       = mk(op_br, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, rf_br_en);
        ex_mem.br_en = 1'b1;
        #1;
        chk("fwd_br_en", mem_fwd_data, 32'h1);
        ex_mem       = mk(op_lui, 3'b000, 32'h0, 32'h0, 5'd1, 1'b1, rf_u_imm);
        ex_mem.u_imm = 32'hABCDE000;
        #1;
        chk("fwd_u_imm", mem_fwd_data, 32'hABCDE000);
        ex_mem = mk(op_jal, 3'b000, 32'h0, 32'h0, 5'd1, 1'b1, rf_pc_plus4);
        #1;
        chk("fwd_pc4", mem_fwd_data, 32'h1004);
        chk("fwd_not_load", 32'(mem_fwd_is_load), 32'd0);
        ex_mem = '0;
        tick();

        // 6: reset while PENDING, then a stray response
        ex_mem = mk(op_load, 3'b010, 32'h500, 32'h0, 5'd5, 1'b1, rf_lw);
        tick();
        ex_mem = '0;
        rst    = 1'b1;
        #1;
        chk("t6_freeze_in_rst", 32'(freeze_stall), 32'd0);
        tick();
        rst       = 1'b0;
        dmem_resp = 1'b1;
        chk("t6_wb_valid", 32'(mem_wb.valid), 32'd0);
        chk("t6_stall_cnt", 32'(stall_cycles), 32'd0);
        #1;
        chk("t6_freeze_stray", 32'(freeze_stall), 32'd0);
        chk("t6_rmask", 32'(dmem_rmask), 32'h0);
        tick();
        dmem_resp = 1'b0;
        #1;
        chk("t6_idle", 32'(freeze_stall), 32'd0);
        ex_mem = mk(op_store, 3'b001, 32'h602, 32'h0000BEEF, 5'd0, 1'b0, rf_alu_out);
        #1;
        chk("t6_sh_wmask", 32'(dmem_wmask), 32'hC);
        chk("t6_sh_wdata", dmem_wdata, 32'hBEEF0000);
        tick();
        ex_mem = '0;
        #1;
        chk("t6_sh_pending", 32'(freeze_stall), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
